// File: rtl/fb_pixel_writer.sv
// ============================================================================
//  fb_pixel_writer : buffers scanner pixels and writes them to the framebuffer
//                    port; also runs a full-screen clear on request.
//  Optional: FB_PIXEL_WRITER_CLIP_EN drops off-screen pixels after accepting them.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fb_pixel_writer #(
    parameter int CORDW      = 9,
    parameter int COLRW      = 4,
    parameter int FB_WIDTH   = 320,
    parameter int FB_HEIGHT  = 240,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDRW      = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             drawing,
    input  logic [CORDW-1:0] x,
    input  logic [CORDW-1:0] y,
    input  logic [COLRW-1:0] colour,
    output logic             oe,
    input  logic             clear_start,
    input  logic [COLRW-1:0] clear_colour,
    output logic             busy,
    output logic             clear_done,
    input  logic             fb_gnt,
    output logic             fb_we,
    output logic [ADDRW-1:0] fb_addr,
    output logic [COLRW-1:0] fb_data
);

    localparam int               PTRW      = $clog2(FIFO_DEPTH);
    localparam int               ENTW      = ADDRW + COLRW;
    localparam logic [PTRW:0]    DEPTH_C   = (PTRW+1)'(FIFO_DEPTH);
    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(FB_WIDTH * FB_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [ENTW-1:0]  mem [FIFO_DEPTH];
    logic [PTRW-1:0]  rd_ptr;
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW:0]    count;
    logic [ADDRW-1:0] clr_addr;
    logic [COLRW-1:0] clr_colour;

    logic [ADDRW-1:0] pix_addr;
    logic             in_range;
    logic             push;
    logic             pop;

    assign pix_addr = ADDRW'(y) * ADDRW'(FB_WIDTH) + ADDRW'(x);

`ifdef FB_PIXEL_WRITER_CLIP_EN
    assign in_range = (32'(x) < FB_WIDTH) && (32'(y) < FB_HEIGHT);
`else
    assign in_range = 1'b1;
`endif

    // A full FIFO never accepts, even when a pop happens in the same cycle.
    assign oe   = (state == IDLE) && (count < DEPTH_C);
    assign push = drawing && oe && in_range;
    assign pop  = (count != '0) && fb_gnt && (state != CLEAR);
    assign busy = (count != '0) || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {pix_addr, colour};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            clear_done <= 1'b0;
            clr_addr   <= '0;
            clr_colour <= '0;
        end else begin
            fb_we      <= 1'b0;
            clear_done <= 1'b0;
            if (pop) begin
                fb_we              <= 1'b1;
                {fb_addr, fb_data} <= mem[rd_ptr];
            end
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state      <= DRAIN;
                        clr_colour <= clear_colour;
                    end
                end
                DRAIN: begin
                    // Buffered pixels land before the clear overwrites them.
                    if (count == '0) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end
                end
                CLEAR: begin
                    if (fb_gnt) begin
                        fb_we   <= 1'b1;
                        fb_addr <= clr_addr;
                        fb_data <= clr_colour;
                        if (clr_addr == LAST_ADDR) begin
                            state      <= DONE;
                            clear_done <= 1'b1;
                        end else begin
                            clr_addr <= clr_addr + 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
